// File: rtl/ctrl_pkg.sv
// Shared control definitions for the RV32I-subset controllers: opcode constants,
// multi-cycle FSM states and the datapath select encodings.
package ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB_ALU,
        S_MEM_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_TRAP
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    // First state after DECODE for a given opcode; unknown opcodes trap.
    function automatic state_t decode_state(input logic [6:0] op);
        case (op)
            R_TYPE, I_TYPE: decode_state = S_EXEC;
            LW, SW:         decode_state = S_MEM_ADDR;
            BR:             decode_state = S_BRANCH;
            JAL:            decode_state = S_JAL;
            JALR:           decode_state = S_JALR;
            default:        decode_state = S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset datapath: sequences fetch, decode,
// execute, memory and write-back, counts retired instructions, flags illegal opcodes.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t             r_state;
    state_t             w_state_next;
    logic [6:0]         r_opcode;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_instret;
    logic               w_retire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_opcode  <= '0;
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_opcode <= opcode;
            end
            if (w_state_next == S_TRAP) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH:    if (mem_ready) w_state_next = S_DECODE;
            S_DECODE:   w_state_next = decode_state(opcode);
            S_EXEC:     w_state_next = S_WB_ALU;
            S_MEM_ADDR: w_state_next = (r_opcode == LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) w_state_next = S_WB_MEM;
            S_MEM_WR: begin
                if (mem_ready) begin
                    w_state_next = S_FETCH;
                    w_retire     = 1'b1;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR: begin
                w_state_next = S_FETCH;
                w_retire     = 1'b1;
            end
            S_TRAP:     w_state_next = S_TRAP;
            default:    w_state_next = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PC_PLUS4;
        alu_src_b     = 1'b0;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        mem_to_reg    = M2R_ALU;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                // Fetch strobes must never fire while reset is being held.
                if (mem_ready && reset_n) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_EXEC: begin
                alu_op    = ALU_FUNCT;
                alu_src_b = (r_opcode == I_TYPE);
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_ALU;
            end
            S_MEM_ADDR: begin
                alu_op    = ALU_ADD;
                alu_src_b = 1'b1;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
            end
            S_BRANCH: begin
                alu_op        = ALU_BR;
                pc_write_cond = 1'b1;
                pc_src        = PC_IMM;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_PC4;
                pc_write   = 1'b1;
                pc_src     = PC_IMM;
            end
            S_JALR: begin
                alu_op     = ALU_ADD;
                alu_src_b  = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = M2R_PC4;
                pc_write   = 1'b1;
                pc_src     = PC_ALU;
            end
            default: ;
        endcase
    end

    assign illegal = r_illegal;
    assign instret = r_instret;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV32I subset datapath (R-type, I-type ALU, LW, SW, BEQ-class branches, JAL, JALR). It sits beside the shared ALU, register file and single-port unified memory, and sequences one instruction at a time through fetch, decode, execute, memory and write-back. Every datapath enable and mux select is driven per state. A retired-instruction counter and a sticky illegal-opcode flag are included.

## Interface

Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction[6:0] from the instruction register; sampled only in DECODE
- mem_ready  in  1  memory completion; the access finishes in any cycle where mem_req=1 and mem_ready=1
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe; valid only while mem_req=1
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- ir_write  out  1  load the instruction register
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by the datapath branch compare
- pc_src  out  2  next-PC select: 00 = PC+4, 01 = PC+imm, 10 = ALU result with bit 0 cleared
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 = add (address), 01 = branch compare, 10 = funct-decoded
- reg_write  out  1  register-file write enable
- mem_to_reg  out  2  write-back select: 00 = ALU, 01 = memory data register, 10 = PC+4 of the current instruction
- illegal  out  1  sticky; set on an unknown opcode
- instret  out  CNT_W  count of retired instructions

## Operation

States:
- FETCH: mem_req=1, iord=0. Hold until mem_ready. In the ready cycle assert ir_write=1, pc_write=1 and pc_src=00, then go to DECODE.
- DECODE: one cycle. Branch on opcode:
  - 0110011 or 0010011 → EXEC
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - any other opcode → TRAP
- EXEC: alu_op=10; alu_src_b = 1 for I-type, 0 for R-type. Next state WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=00. Retire, go to FETCH.
- MEM_ADDR: alu_op=00, alu_src_b=1. Next state MEM_RD for load, MEM_WR for store.
- MEM_RD: mem_req=1, iord=1, mem_we=0. Hold until mem_ready, then go to WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=01. Retire, go to FETCH.
- MEM_WR: mem_req=1, iord=1, mem_we=1. On mem_ready, retire and go to FETCH.
- BRANCH: alu_op=01, alu_src_b=0, pc_write_cond=1, pc_src=01. Retire, go to FETCH.
- JAL: reg_write=1, mem_to_reg=10, pc_write=1, pc_src=01. Retire, go to FETCH.
- JALR: alu_op=00, alu_src_b=1, reg_write=1, mem_to_reg=10, pc_write=1, pc_src=10. Retire, go to FETCH.
- TRAP: illegal=1. All enables 0. Terminal state; only reset_n exits it.

Rules:
- The opcode is latched into an internal register in DECODE. Later states decode the latched copy, so IR changes do not affect them.
- Outputs are a combinational function of the state and the latched opcode. The one exception is the FETCH ready-cycle strobes, which are also gated by mem_ready.
- Any output not listed for a state is 0.
- "Retire" means instret increments by 1 on that state's exit edge. It wraps modulo 2^CNT_W.
- A JAL write-back uses the PC+4 captured at FETCH. The rd write and the PC load happen on the same edge.

## Timing

- Reset, asynchronous, while reset_n=0:
  - state=FETCH, instret=0, illegal=0, latched opcode=0.
  - Outputs read as FETCH: mem_req=1, iord=0, all others 0.
  - ir_write and pc_write stay 0 while reset_n=0, even if mem_ready=1.
- Reset asserted mid-instruction aborts it immediately. No write-enable pulse is generated.
- Latency with mem_ready tied to 1, fetch edge to next fetch:
  - R/I: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - branch: 3 cycles
  - JAL/JALR: 3 cycles
- Each memory wait cycle adds 1 cycle.
- mem_req stays high without gaps across wait cycles. mem_we and iord are stable for the whole request.
- mem_ready=1 outside a request is ignored.
- Exactly one ir_write pulse occurs per instruction.

## Structure

- Package ctrl_pkg holds:
  - the opcode constants (R_TYPE, I_TYPE, LW, SW, BR, JAL, JALR)
  - the state enum
  - the alu_op, pc_src and mem_to_reg encodings
- The package is shared with the single-cycle Controller and the ALU controller.
- The design is a single module with no sub-modules: a state register, a next-state process and an output decode process. instret is a plain counter in the same module.

## Test plan

- R-type add, mem_ready=1: 4-cycle sequence FETCH→DECODE→EXEC→WB_ALU. reg_write is high exactly in cycle 4. instret goes from 0 to 1.
- LW, with mem_ready delayed 3 cycles in MEM_RD: mem_req=1 and iord=1 held for 4 cycles, then WB_MEM with mem_to_reg=01. Total 8 cycles.
- SW: mem_we=1 only in MEM_WR. reg_write stays 0 throughout. 4 cycles.
- BEQ: pc_write_cond=1 and pc_src=01 in cycle 3. JALR: pc_src=10, mem_to_reg=10, reg_write=1.
- Opcode 0000000: TRAP, illegal=1 held for 100 cycles with no enables asserted. Pulsing reset_n low returns the FSM to FETCH with illegal=0.
- Reset_n pulsed low in MEM_WR while mem_ready=1: no mem_we pulse is completed, the FSM returns to FETCH, and instret=0.
- Preload instret=2^CNT_W−1 (CNT_W=4), then retire one instruction: instret=0.
